flag_branch_unit: RTL and testbench
===================================

Name: flag_branch_unit

Overview:
- Execute-stage consumer of the 16-bit ALU (saturating add/sub, shifter, parallel sub-word add).
- Holds the architectural Z/V/N flag register and updates it per opcode from the ALU result and overflow.
- Resolves conditional branches against the flags, forwarding same-cycle updates, and registers the taken/resolved decision for the fetch stage.
- Keeps a saturating count of overflow events for debug.

Parameters:
- WIDTH, 16: ALU result width.
- CNT_W, 16: width of the overflow event counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- stall  input  1  pipeline stall; every register holds its value
- flush  input  1  squashes the current EX instruction and any pending branch
- ex_valid  input  1  a valid instruction is in EX this cycle
- ex_op  input  4  opcode of the EX instruction
- alu_result  input  WIDTH  ALU output, already saturated
- alu_ovfl  input  1  ALU overflow indication
- br_valid  input  1  a branch is requesting resolution this cycle
- br_cond  input  3  branch condition code
- flag_z  output  1  zero flag
- flag_v  output  1  overflow flag
- flag_n  output  1  negative flag
- br_resolved  output  1  registered: a branch was resolved last cycle
- br_taken  output  1  registered: that branch is taken
- ovfl_count  output  CNT_W  saturating count of V=1 updates

Behaviour:
- Reset: flag_z, flag_v, flag_n, br_resolved, br_taken = 0 and ovfl_count = 0, asynchronously.
- Update enable: upd = ex_valid & ~stall & ~flush.
- Next-flag values:
  - nz = (alu_result == 0).
  - nn = alu_result[WIDTH-1].
  - nv = alu_ovfl.
- Flag write mask by opcode:
  - ADD 4'h0, SUB 4'h1: write Z, V, N.
  - XOR 4'h2, SLL 4'h4, SRA 4'h5, ROR 4'h6: write Z only.
  - All other opcodes (RED, PADDSB, memory, LLB/LHB, branches, PCS, HLT): no write.
- Flags change on the clock edge after upd. Latency is 1 cycle from EX to flag outputs.
- Forwarding: branch evaluation uses effective flags. A flag takes its next-flag value when upd is set and its mask bit is set; otherwise it keeps the registered value. This removes the flag hazard when a flag-setting instruction and a branch meet in the same cycle.
- Condition codes, evaluated on effective flags:
  - 000 NE: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z & ~N
  - 011 LT: N
  - 100 GE: Z | (~Z & ~N)
  - 101 LE: N | Z
  - 110 OV: V
  - 111 UN: always 1
- Branch registers:
  - Normal cycle (not stall, not flush): br_resolved <= br_valid; br_taken <= br_valid & cond_true.
  - stall: hold both.
  - flush: both cleared to 0 next edge, and a branch presented that cycle is dropped. Flags are not modified by flush.
- The resolved/taken pair is a 1-cycle pulse per branch (no back-to-back merge). Consecutive br_valid cycles each produce their own pulse.
- ovfl_count: increments on upd & (op is ADD or SUB) & alu_ovfl. Holds at all-ones and never wraps.
- stall and flush asserted together: flush wins. Registers clear as for flush and no update occurs.
- Reset mid-branch: pending resolution is lost, and outputs read 0 until the first post-reset edge with activity.

Decomposition:
- Package flag_branch_pkg holds:
  - opcode localparams: OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_SRA, OP_ROR;
  - condition enum cond_t (3 bits, encodings above);
  - typedef flags_t struct {z, v, n}.
- Sub-module branch_cond_eval: purely combinational, inputs cond_t and flags_t, output taken. It is reused by the BR/register-branch path.

Test Plan:
- Reset check: assert rst mid-cycle with nonzero state -> all outputs 0 immediately, without waiting for a clock edge.
- ADD flags: ex_op=0, alu_result=16'h8000, alu_ovfl=1 -> next cycle Z=0, V=1, N=1, ovfl_count=1. Then XOR with result 0 -> Z=1 while V=1 and N=1 are held.
- Forwarding: prior Z=0. Same cycle: SUB with result 0 plus br_valid, cond=001 (EQ) -> next cycle br_resolved=1, br_taken=1, Z=1.
- Stall/flush: ADD result 0 with stall=1 -> flags unchanged. Branch UN with flush=1 -> br_resolved=0, br_taken=0. With stall and flush both set -> flush behaviour.
- Condition sweep: for each of the 8 flag combinations, each of the 8 codes -> br_taken matches the equations above.
- Counter saturation: CNT_W=4, 17 overflowing ADDs -> ovfl_count stops at 4'hF.

Source files
------------

// File: rtl/flag_branch_pkg.sv
// Shared types and constants for the execute-stage flag/branch unit:
// ALU opcodes that touch flags, branch condition encodings, the flag
// register layout and small decode helpers.
package flag_branch_pkg;

  // Opcodes that write flags
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;

  // Branch condition codes
  typedef enum logic [2:0] {
    COND_NE = 3'b000,
    COND_EQ = 3'b001,
    COND_GT = 3'b010,
    COND_LT = 3'b011,
    COND_GE = 3'b100,
    COND_LE = 3'b101,
    COND_OV = 3'b110,
    COND_UN = 3'b111
  } cond_t;

  // Architectural flag register
  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

  // Which flags an opcode is allowed to write.
  function automatic flags_t flag_mask(input logic [3:0] op);
    flags_t m;
    case (op)
      OP_ADD, OP_SUB:         m = '{z: 1'b1, v: 1'b1, n: 1'b1};
      OP_XOR, OP_SLL,
      OP_SRA, OP_ROR:         m = '{z: 1'b1, v: 1'b0, n: 1'b0};
      default:                m = '{z: 1'b0, v: 1'b0, n: 1'b0};
    endcase
    return m;
  endfunction

  // Arithmetic ops whose overflow is counted for debug.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/flag_branch_unit_if.sv
// Execute-stage bundle between the pipeline and the flag/branch unit.
// The master side presents pipeline control, the EX instruction result
// and a branch request; the slave side returns flags, the registered
// branch decision and the overflow event count.
interface flag_branch_unit_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);

  // Pipeline control
  logic             stall;
  logic             flush;

  // EX instruction
  logic             ex_valid;
  logic [3:0]       ex_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_ovfl;

  // Branch request
  logic             br_valid;
  logic [2:0]       br_cond;

  // Results
  logic             flag_z;
  logic             flag_v;
  logic             flag_n;
  logic             br_resolved;
  logic             br_taken;
  logic [CNT_W-1:0] ovfl_count;

  modport master (
    output stall, flush, ex_valid, ex_op, alu_result, alu_ovfl,
           br_valid, br_cond,
    input  flag_z, flag_v, flag_n, br_resolved, br_taken, ovfl_count
  );

  modport slave (
    input  stall, flush, ex_valid, ex_op, alu_result, alu_ovfl,
           br_valid, br_cond,
    output flag_z, flag_v, flag_n, br_resolved, br_taken, ovfl_count
  );

endinterface

// File: rtl/flag_branch_unit_cond_eval.sv
// Combinational branch condition evaluator. Shared with the
// register-branch path, so it only sees a condition code and a flag set.
module branch_cond_eval
  import flag_branch_pkg::*;
(
  input  cond_t  cond,
  input  flags_t flags,
  output logic   taken
);

  // Decode the condition code against the supplied flags
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_NE: taken = ~flags.z;
      COND_EQ: taken = flags.z;
      COND_GT: taken = ~flags.z & ~flags.n;
      COND_LT: taken = flags.n;
      COND_GE: taken = flags.z | (~flags.z & ~flags.n);
      COND_LE: taken = flags.n | flags.z;
      COND_OV: taken = flags.v;
      COND_UN: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Execute-stage flag register and branch resolver. Flags are updated
// per opcode from the ALU result; branches see the flags an in-flight
// flag-setting instruction is about to write, so a compare and its
// branch can share a cycle. The branch decision is registered as a
// one-cycle pulse for fetch, and overflow events are counted (saturating).
module flag_branch_unit
  import flag_branch_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  flag_branch_unit_if.slave  bus
);

  logic             upd_s;
  logic             run_s;
  flags_t           mask_s;
  flags_t           next_flags_s;
  flags_t           eff_flags_s;
  logic             cond_true_s;
  logic             cnt_inc_s;

  flags_t           flags_r;
  logic             br_resolved_r;
  logic             br_taken_r;
  logic [CNT_W-1:0] ovfl_count_r;

  // A flushed or stalled instruction never writes architectural state
  assign run_s = ~bus.stall & ~bus.flush;
  assign upd_s = bus.ex_valid & run_s;

  // Candidate flag values and the opcode's write mask
  always_comb begin
    next_flags_s.z = (bus.alu_result == {WIDTH{1'b0}});
    next_flags_s.n = bus.alu_result[WIDTH-1];
    next_flags_s.v = bus.alu_ovfl;
    mask_s         = flag_mask(bus.ex_op);
  end

  // Effective flags: forward this cycle's write so a same-cycle branch
  // sees it; also serves as the flag register's next state
  always_comb begin
    eff_flags_s = flags_r;
    if (upd_s) begin
      eff_flags_s.z = mask_s.z ? next_flags_s.z : flags_r.z;
      eff_flags_s.v = mask_s.v ? next_flags_s.v : flags_r.v;
      eff_flags_s.n = mask_s.n ? next_flags_s.n : flags_r.n;
    end else begin
      eff_flags_s = flags_r;
    end
  end

  branch_cond_eval u_cond_eval (
    .cond  (cond_t'(bus.br_cond)),
    .flags (eff_flags_s),
    .taken (cond_true_s)
  );

  // Overflow event qualifier; stops at all-ones so it never wraps
  assign cnt_inc_s = upd_s & is_arith(bus.ex_op) & bus.alu_ovfl &
                     (ovfl_count_r != {CNT_W{1'b1}});

  // Architectural flag register (eff_flags_s already holds when idle)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_r <= '{z: 1'b0, v: 1'b0, n: 1'b0};
    end else begin
      flags_r <= eff_flags_s;
    end
  end

  // Registered branch decision: flush drops it, stall holds it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_resolved_r <= 1'b0;
      br_taken_r    <= 1'b0;
    end else if (bus.flush) begin
      br_resolved_r <= 1'b0;
      br_taken_r    <= 1'b0;
    end else if (bus.stall) begin
      br_resolved_r <= br_resolved_r;
      br_taken_r    <= br_taken_r;
    end else begin
      br_resolved_r <= bus.br_valid;
      br_taken_r    <= bus.br_valid & cond_true_s;
    end
  end

  // Saturating overflow event counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovfl_count_r <= {CNT_W{1'b0}};
    end else if (cnt_inc_s) begin
      ovfl_count_r <= ovfl_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      ovfl_count_r <= ovfl_count_r;
    end
  end

  assign bus.flag_z      = flags_r.z;
  assign bus.flag_v      = flags_r.v;
  assign bus.flag_n      = flags_r.n;
  assign bus.br_resolved = br_resolved_r;
  assign bus.br_taken    = br_taken_r;
  assign bus.ovfl_count  = ovfl_count_r;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: flag updates, forwarding,
// stall/flush, a full condition sweep, async reset and counter saturation.
module tb_flag_branch_unit;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  flag_branch_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  flag_branch_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic [3:0] op,
                       input logic [15:0] res, input logic ov,
                       input logic bv, input logic [2:0] cond,
                       input logic st, input logic fl);
    bus.ex_valid   = ev;
    bus.ex_op      = op;
    bus.alu_result = res;
    bus.alu_ovfl   = ov;
    bus.br_valid   = bv;
    bus.br_cond    = cond;
    bus.stall      = st;
    bus.flush      = fl;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic z,
                             input logic v, input logic n);
    check_val({tag, "_z"}, {31'd0, bus.flag_z}, {31'd0, z});
    check_val({tag, "_v"}, {31'd0, bus.flag_v}, {31'd0, v});
    check_val({tag, "_n"}, {31'd0, bus.flag_n}, {31'd0, n});
  endtask

  task automatic check_br(input string tag, input logic res,
                          input logic tk);
    check_val({tag, "_res"}, {31'd0, bus.br_resolved}, {31'd0, res});
    check_val({tag, "_tkn"}, {31'd0, bus.br_taken}, {31'd0, tk});
  endtask

  task automatic check_cnt(input string tag, input logic [3:0] c);
    check_val({tag, "_cnt"}, {28'd0, bus.ovfl_count}, {28'd0, c});
  endtask

  function automatic logic ref_cond(input logic [2:0] c, input logic z,
                                    input logic v, input logic n);
    case (c)
      3'd0:    return !z;
      3'd1:    return z;
      3'd2:    return !z && !n;
      3'd3:    return n;
      3'd4:    return z || !n;
      3'd5:    return n || z;
      3'd6:    return v;
      default: return 1'b1;
    endcase
  endfunction

  initial begin
    logic z, v, n;
    logic [3:0] exp_cnt;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    step();
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    check_br("rst", 1'b0, 1'b0);
    check_cnt("rst", 4'h0);

    // ADD 0x8000 with overflow, then XOR to zero writes only Z
    drive(1'b1, 4'h0, 16'h8000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    step();
    check_flags("add", 1'b0, 1'b1, 1'b1);
    check_cnt("add", 4'h1);
    drive(1'b1, 4'h2, 16'h0000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    step();
    check_flags("xor", 1'b1, 1'b1, 1'b1);

    // Clear flags with a positive ADD; RED (no-write op) overflow ignored
    drive(1'b1, 4'h0, 16'h0001, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    step();
    check_flags("add_pos", 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'h3, 16'h0000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    step();
    check_flags("red", 1'b0, 1'b0, 1'b0);
    check_cnt("red", 4'h1);

    // Forwarding: SUB -> 0 with EQ branch in the same cycle
    drive(1'b1, 4'h1, 16'h0000, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0);
    step();
    check_br("fwd", 1'b1, 1'b1);
    check_flags("fwd", 1'b1, 1'b0, 1'b0);
    idle();
    step();
    check_br("pulse_end", 1'b0, 1'b0);

    // GT with Z=1 is not taken; then two back-to-back UN pulses
    drive(1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0);
    step();
    check_br("gt", 1'b1, 1'b0);
    drive(1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0);
    step();
    check_br("un1", 1'b1, 1'b1);
    step();
    check_br("un2", 1'b1, 1'b1);

    // Stall holds the branch pair and blocks the ADD
    drive(1'b1, 4'h0, 16'h8000, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0);
    step();
    check_br("stall", 1'b1, 1'b1);
    check_flags("stall", 1'b1, 1'b0, 1'b0);
    check_cnt("stall", 4'h1);

    // Flush drops the branch and the ADD
    drive(1'b1, 4'h0, 16'h8000, 1'b1, 1'b1, 3'b111, 1'b0, 1'b1);
    step();
    check_br("flush", 1'b0, 1'b0);
    check_flags("flush", 1'b1, 1'b0, 1'b0);
    check_cnt("flush", 4'h1);

    // Stall and flush together: flush wins
    drive(1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0);
    step();
    check_br("pre_sf", 1'b1, 1'b1);
    drive(1'b1, 4'h0, 16'h8000, 1'b1, 1'b1, 3'b111, 1'b1, 1'b1);
    step();
    check_br("stfl", 1'b0, 1'b0);
    check_flags("stfl", 1'b1, 1'b0, 1'b0);
    check_cnt("stfl", 4'h1);

    // Condition sweep over all flag combinations and codes
    exp_cnt = 4'h1;
    for (int f = 0; f < 8; f++) begin
      z = f[2];
      v = f[1];
      n = f[0];
      drive(1'b1, 4'h0, n ? 16'h8000 : 16'h0001, v, 1'b0, 3'b000,
            1'b0, 1'b0);
      step();
      drive(1'b1, 4'h2, z ? 16'h0000 : 16'h0001, 1'b0, 1'b0, 3'b000,
            1'b0, 1'b0);
      step();
      if (v) exp_cnt = exp_cnt + 4'h1;
      check_flags($sformatf("ld%0d", f), z, v, n);
      for (int c = 0; c < 8; c++) begin
        drive(1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, c[2:0], 1'b0, 1'b0);
        step();
        check_br($sformatf("cond_f%0d_c%0d", f, c), 1'b1,
                 ref_cond(c[2:0], z, v, n));
      end
    end
    check_cnt("sweep", exp_cnt);

    // Asynchronous reset mid-cycle with nonzero state
    #2;
    rst = 1'b1;
    #1;
    check_flags("arst", 1'b0, 1'b0, 1'b0);
    check_br("arst", 1'b0, 1'b0);
    check_cnt("arst", 4'h0);
    idle();
    step();
    rst = 1'b0;
    step();
    check_br("post_rst", 1'b0, 1'b0);

    // Counter saturation: 17 overflowing ADDs stop at F
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 4'h0, 16'h8000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
      step();
      check_cnt($sformatf("sat%0d", i), (i > 15) ? 4'hF : i[3:0]);
    end
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
